// File: rtl/pl_perf_monitor_if.sv
// Purpose : groups the run-control and counter read-out signals of pl_perf_monitor.
// Latency : n/a (wiring only).
// Backpressure: none; all strobes are single-cycle and always accepted.
// Ports   : master drives start/hlt_seen/stall/event_in/rd_sel and observes results;
//           slave is the monitor, driving rd_data, live counters, ovf, busy, done, timeout.
interface pl_perf_monitor_if #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_W      = 32
);
  logic                  start;
  logic                  hlt_seen;
  logic                  stall;
  logic [NUM_EVENTS-1:0] event_in;
  logic [3:0]            rd_sel;
  logic [CNT_W-1:0]      rd_data;
  logic [CNT_W-1:0]      cycles_consumed;
  logic [CNT_W-1:0]      StallCount;
  logic [NUM_EVENTS+1:0] ovf;
  logic                  busy;
  logic                  done;
  logic                  timeout;

  modport master (
    output start, hlt_seen, stall, event_in, rd_sel,
    input  rd_data, cycles_consumed, StallCount, ovf, busy, done, timeout
  );

  modport slave (
    input  start, hlt_seen, stall, event_in, rd_sel,
    output rd_data, cycles_consumed, StallCount, ovf, busy, done, timeout
  );
endinterface

// File: rtl/pl_perf_monitor.sv
// Purpose : run-control FSM (IDLE/RUN/DRAIN/DONE) with cycle, stall and event counters and a watchdog.
// Latency : live counters update on the counting edge; rd_data is one cycle behind rd_sel.
// Backpressure: none; inputs are sampled every cycle and ignored outside the states that use them.
// Ports   : input_clk, rst (async, active-high) plus bus (slave modport of pl_perf_monitor_if).
module pl_perf_monitor #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_W      = 32,
  parameter int MAX_CLOCKS = 100000,
  parameter int HALT_DRAIN = 4,
  parameter int SATURATE   = 1
) (
  input logic               input_clk,
  input logic               rst,
  pl_perf_monitor_if.slave  bus
);
  // Counter index 0 = cycles, 1 = stalls, 2+i = event i (same order as rd_sel and ovf).
  localparam int NUM_CNT = NUM_EVENTS + 2;

  // The watchdog is compared at 65 bits so a limit that cannot be represented
  // in CNT_W bits simply never matches instead of aliasing onto a smaller value.
  localparam logic [64:0] MAX_W      = 65'(MAX_CLOCKS);
  localparam bit          WD_EN      = (MAX_CLOCKS != 0) && ((MAX_W >> CNT_W) == 65'd0);
  localparam logic [3:0]  DRAIN_LAST = 4'(HALT_DRAIN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                         state_q, state_d;
  logic [3:0]                     drain_q, drain_d;
  logic [NUM_CNT-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CNT-1:0]             ovf_q, ovf_d;
  logic                           timeout_q, timeout_d;
  logic [CNT_W-1:0]               rd_data_q, rd_data_d;
  logic [NUM_CNT-1:0]             inc;

  // Cycle counter always increments in RUN, so its strobe is a constant 1.
  assign inc = {bus.event_in, bus.stall, 1'b1};

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    timeout_d = timeout_q;
    rd_data_d = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          ovf_d     = '0;
          timeout_d = 1'b0;
        end
      end

      S_RUN: begin
        for (int i = 0; i < NUM_CNT; i++) begin
          if (inc[i]) begin
            if (&cnt_q[i]) begin
              ovf_d[i] = 1'b1;
              cnt_d[i] = (SATURATE != 0) ? cnt_q[i] : '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
        end
        // Halt takes priority over a watchdog hit in the same cycle.
        if (bus.hlt_seen) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else if (WD_EN && (65'(cnt_d[0]) == MAX_W)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end

      S_DRAIN: begin
        // drain_q counts 0..HALT_DRAIN, so done lands HALT_DRAIN+1 edges after the halt edge.
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Read port samples the post-edge counter value; out-of-range selects read 0.
    for (int i = 0; i < NUM_CNT; i++) begin
      if (bus.rd_sel == 4'(i)) begin
        rd_data_d = cnt_d[i];
      end
    end
  end

  always_ff @(posedge input_clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      drain_q   <= '0;
      cnt_q     <= '0;
      ovf_q     <= '0;
      timeout_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      timeout_q <= timeout_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.rd_data         = rd_data_q;
  assign bus.cycles_consumed = cnt_q[0];
  assign bus.StallCount      = cnt_q[1];
  assign bus.ovf             = ovf_q;
  assign bus.busy            = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done            = (state_q == S_DONE);
  assign bus.timeout         = timeout_q;
endmodule

// File: tb/tb_pl_perf_monitor.sv
// Purpose : self-checking bench for pl_perf_monitor (four parameterisations share one stimulus).
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled there too.
// Backpressure: n/a.
module tb_pl_perf_monitor;
  localparam int HD = 4;

  logic       clk;
  logic       rst;
  logic       start, hlt_seen, stall;
  logic [3:0] event_in;
  logic [3:0] rd_sel;

  int checks = 0;
  int errors = 0;

  // main: defaults; wd: MAX_CLOCKS=20; s8/w8: 8-bit counters saturating / wrapping
  pl_perf_monitor_if #(.NUM_EVENTS(4), .CNT_W(32)) if_main ();
  pl_perf_monitor_if #(.NUM_EVENTS(4), .CNT_W(32)) if_wd ();
  pl_perf_monitor_if #(.NUM_EVENTS(4), .CNT_W(8))  if_s8 ();
  pl_perf_monitor_if #(.NUM_EVENTS(4), .CNT_W(8))  if_w8 ();

  pl_perf_monitor u_main (.input_clk(clk), .rst(rst), .bus(if_main.slave));
  pl_perf_monitor #(.MAX_CLOCKS(20)) u_wd (.input_clk(clk), .rst(rst), .bus(if_wd.slave));
  pl_perf_monitor #(.CNT_W(8), .SATURATE(1)) u_s8 (.input_clk(clk), .rst(rst), .bus(if_s8.slave));
  pl_perf_monitor #(.CNT_W(8), .SATURATE(0)) u_w8 (.input_clk(clk), .rst(rst), .bus(if_w8.slave));

  assign if_main.start = start;   assign if_main.hlt_seen = hlt_seen; assign if_main.stall = stall;
  assign if_main.event_in = event_in; assign if_main.rd_sel = rd_sel;
  assign if_wd.start = start;     assign if_wd.hlt_seen = hlt_seen;   assign if_wd.stall = stall;
  assign if_wd.event_in = event_in;   assign if_wd.rd_sel = rd_sel;
  assign if_s8.start = start;     assign if_s8.hlt_seen = hlt_seen;   assign if_s8.stall = stall;
  assign if_s8.event_in = event_in;   assign if_s8.rd_sel = rd_sel;
  assign if_w8.start = start;     assign if_w8.hlt_seen = hlt_seen;   assign if_w8.stall = stall;
  assign if_w8.event_in = event_in;   assign if_w8.rd_sel = rd_sel;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic h, input logic st, input logic [3:0] ev);
    start    = s;
    hlt_seen = h;
    stall    = st;
    event_in = ev;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    drive(0, 0, 0, 4'h0);
    tick();
  endtask

  typedef struct {
    logic       start;
    logic       hlt;
    logic       stall;
    logic [3:0] ev;
    logic       busy;
    logic       done;
    int         cyc;
    int         stl;
  } vec_t;

  typedef struct {
    logic [3:0] sel;
    int         exp;
  } rd_vec_t;

  vec_t    tbl[18];
  rd_vec_t rtbl[8];

  // random-run bookkeeping
  int          run_len, exp_stl, wd_cyc;
  int          exp_cnt[6];
  logic        st_r, sp_r;
  logic [3:0]  ev_r;

  initial begin
    // start hlt stall ev    busy done cyc stl
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 0,  0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 1,  0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'h2, 1'b1, 1'b0, 2,  0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 3,  1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 4'h4, 1'b1, 1'b0, 4,  2};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 5,  3};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 4'h6, 1'b1, 1'b0, 6,  3};  // start ignored in RUN
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'h7, 1'b1, 1'b0, 7,  3};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'h8, 1'b1, 1'b0, 8,  3};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'h9, 1'b1, 1'b0, 9,  3};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 4'ha, 1'b1, 1'b0, 10, 3};  // halt edge, counted
    tbl[11] = '{1'b0, 1'b0, 1'b1, 4'hf, 1'b1, 1'b0, 10, 3};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 4'hf, 1'b1, 1'b0, 10, 3};  // start ignored in DRAIN
    tbl[13] = '{1'b0, 1'b1, 1'b0, 4'hf, 1'b1, 1'b0, 10, 3};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 4'hf, 1'b1, 1'b0, 10, 3};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 4'hf, 1'b0, 1'b1, 10, 3};  // halt edge + HD + 1
    tbl[16] = '{1'b0, 1'b0, 1'b1, 4'hf, 1'b0, 1'b1, 10, 3};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 4'hf, 1'b0, 1'b1, 10, 3};

    rtbl[0] = '{4'd0, 10};
    rtbl[1] = '{4'd1, 3};
    rtbl[2] = '{4'd2, 5};
    rtbl[3] = '{4'd3, 5};
    rtbl[4] = '{4'd4, 4};
    rtbl[5] = '{4'd5, 3};
    rtbl[6] = '{4'd6, 0};
    rtbl[7] = '{4'd15, 0};

    // ---------------- reset ----------------
    rst = 1'b0;
    rd_sel = 4'd0;
    drive(0, 0, 0, 4'h0);
    #1 rst = 1'b1;
    #2;
    chk("rst_rd_data", if_main.rd_data, 0);
    chk("rst_cycles", if_main.cycles_consumed, 0);
    chk("rst_stalls", if_main.StallCount, 0);
    chk("rst_ovf", if_main.ovf, 0);
    chk("rst_busy", if_main.busy, 0);
    chk("rst_done", if_main.done, 0);
    chk("rst_timeout", if_main.timeout, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_busy", if_main.busy, 0);

    // ---------------- basic run (table) ----------------
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].start, tbl[i].hlt, tbl[i].stall, tbl[i].ev);
      tick();
      chk($sformatf("tbl%0d_busy", i), if_main.busy, tbl[i].busy);
      chk($sformatf("tbl%0d_done", i), if_main.done, tbl[i].done);
      chk($sformatf("tbl%0d_cycles", i), if_main.cycles_consumed, tbl[i].cyc);
      chk($sformatf("tbl%0d_stalls", i), if_main.StallCount, tbl[i].stl);
    end
    chk("basic_timeout", if_main.timeout, 0);
    chk("basic_ovf", if_main.ovf, 0);

    // ---------------- read port after DONE ----------------
    drive(0, 0, 0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      rd_sel = rtbl[i].sel;
      tick();
      chk($sformatf("rd_sel%0d", rtbl[i].sel), if_main.rd_data, rtbl[i].exp);
    end
    rd_sel = 4'd0;

    // ---------------- watchdog, no halt ----------------
    pulse_rst();
    drive(1, 0, 0, 4'h0);
    tick();
    drive(0, 0, 0, 4'h0);
    for (int j = 1; j <= 25; j++) begin
      tick();
      if (j == 19) begin
        chk("wd19_done", if_wd.done, 0);
        chk("wd19_cycles", if_wd.cycles_consumed, 19);
      end else if (j >= 20) begin
        chk($sformatf("wd%0d_done", j), if_wd.done, 1);
        chk($sformatf("wd%0d_timeout", j), if_wd.timeout, 1);
        chk($sformatf("wd%0d_cycles", j), if_wd.cycles_consumed, 20);
        chk($sformatf("wd%0d_busy", j), if_wd.busy, 0);
      end
    end
    chk("wd_main_still_busy", if_main.busy, 1);

    // ---------------- watchdog cycle coincides with halt ----------------
    pulse_rst();
    drive(1, 0, 0, 4'h0);
    tick();
    for (int j = 1; j <= 20; j++) begin
      drive(0, j == 20, 0, 4'h0);
      tick();
    end
    chk("wdh_busy", if_wd.busy, 1);
    chk("wdh_done", if_wd.done, 0);
    chk("wdh_timeout", if_wd.timeout, 0);
    chk("wdh_cycles", if_wd.cycles_consumed, 20);
    drive(0, 0, 0, 4'h0);
    for (int d = 1; d <= HD + 1; d++) tick();
    chk("wdh_done_end", if_wd.done, 1);
    chk("wdh_timeout_end", if_wd.timeout, 0);

    // ---------------- 8-bit overflow: saturate vs wrap ----------------
    pulse_rst();
    rd_sel = 4'd2;
    drive(1, 0, 0, 4'h0);
    tick();
    drive(0, 0, 0, 4'h1);
    for (int j = 1; j <= 300; j++) begin
      tick();
      if (j == 255) begin
        chk("ov255_sat", if_s8.rd_data, 255);
        chk("ov255_sat_ovf", if_s8.ovf[2], 0);
        chk("ov255_wrap", if_w8.rd_data, 255);
        chk("ov255_wrap_ovf", if_w8.ovf[2], 0);
      end else if (j == 256) begin
        chk("ov256_sat", if_s8.rd_data, 255);
        chk("ov256_sat_ovf", if_s8.ovf[2], 1);
        chk("ov256_wrap", if_w8.rd_data, 0);
        chk("ov256_wrap_ovf", if_w8.ovf[2], 1);
      end
    end
    chk("ov300_sat_ev0", if_s8.rd_data, 255);
    chk("ov300_sat_ovf", if_s8.ovf, 6'b000101);
    chk("ov300_sat_cycles", if_s8.cycles_consumed, 255);
    chk("ov300_wrap_ev0", if_w8.rd_data, 44);
    chk("ov300_wrap_ovf", if_w8.ovf, 6'b000101);
    chk("ov300_wrap_cycles", if_w8.cycles_consumed, 44);
    chk("ov300_sat_busy", if_s8.busy, 1);

    // ---------------- reset mid-DRAIN, then restart ----------------
    pulse_rst();
    rd_sel = 4'd0;
    drive(1, 0, 0, 4'h0);
    tick();
    for (int j = 1; j <= 3; j++) begin
      drive(0, j == 3, 1, 4'hf);
      tick();
    end
    drive(0, 0, 0, 4'h0);
    tick();
    tick();
    chk("mid_drain_busy", if_main.busy, 1);
    chk("mid_drain_rd", if_main.rd_data, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", if_main.busy, 0);
    chk("arst_cycles", if_main.cycles_consumed, 0);
    chk("arst_stalls", if_main.StallCount, 0);
    chk("arst_rd", if_main.rd_data, 0);
    chk("arst_ovf", if_main.ovf, 0);
    chk("arst_done", if_main.done, 0);
    #1 rst = 1'b0;
    drive(1, 0, 0, 4'h0);
    tick();
    for (int j = 1; j <= 7; j++) begin
      drive(0, j == 7, 0, 4'h0);
      tick();
    end
    drive(0, 0, 0, 4'h0);
    for (int d = 1; d <= HD + 1; d++) tick();
    chk("run7_done", if_main.done, 1);
    chk("run7_cycles", if_main.cycles_consumed, 7);
    drive(1, 0, 0, 4'h0);
    tick();
    chk("restart_cleared", if_main.cycles_consumed, 0);
    for (int j = 1; j <= 5; j++) begin
      drive(0, j == 5, 0, 4'h0);
      tick();
    end
    chk("run5_cycles", if_main.cycles_consumed, 5);

    // ---------------- randomized runs vs. transaction-level model ----------------
    drive(0, 0, 0, 4'h0);
    for (int d = 1; d <= HD + 1; d++) tick();
    for (int r = 0; r < 20; r++) begin
      run_len = $urandom_range(1, 30);
      for (int k = 0; k < 6; k++) exp_cnt[k] = 0;
      exp_cnt[0] = run_len;
      drive(1, 0, 1'($urandom), 4'($urandom));
      tick();
      chk($sformatf("r%0d_start_busy", r), if_main.busy, 1);
      chk($sformatf("r%0d_start_cleared", r), if_main.cycles_consumed, 0);
      for (int j = 1; j <= run_len; j++) begin
        st_r = 1'($urandom);
        ev_r = 4'($urandom);
        sp_r = (j < run_len && j < 19) ? ($urandom_range(0, 3) == 0) : 1'b0;
        drive(sp_r, j == run_len, st_r, ev_r);
        if (st_r) exp_cnt[1]++;
        for (int k = 0; k < 4; k++) if (ev_r[k]) exp_cnt[2 + k]++;
        tick();
      end
      chk($sformatf("r%0d_cycles", r), if_main.cycles_consumed, exp_cnt[0]);
      chk($sformatf("r%0d_stalls", r), if_main.StallCount, exp_cnt[1]);
      for (int d = 1; d <= HD + 1; d++) begin
        drive(0, 1'($urandom), 1'($urandom), 4'($urandom));
        tick();
        chk($sformatf("r%0d_d%0d_done", r, d), if_main.done, d == HD + 1);
        chk($sformatf("r%0d_d%0d_busy", r, d), if_main.busy, d != HD + 1);
      end
      chk($sformatf("r%0d_cycles_frozen", r), if_main.cycles_consumed, exp_cnt[0]);
      chk($sformatf("r%0d_timeout", r), if_main.timeout, 0);
      wd_cyc = (run_len > 20) ? 20 : run_len;
      chk($sformatf("r%0d_wd_timeout", r), if_wd.timeout, run_len > 20);
      chk($sformatf("r%0d_wd_cycles", r), if_wd.cycles_consumed, wd_cyc);
      drive(0, 0, 0, 4'h0);
      for (int k = 0; k < 6; k++) begin
        rd_sel = 4'(k);
        tick();
        chk($sformatf("r%0d_rd%0d", r, k), if_main.rd_data, exp_cnt[k]);
      end
      rd_sel = 4'd0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
